// File: rtl/adv_counter_pkg.sv
// -----------------------------------------------------------------------------
// adv_counter_pkg
// Shared constants for the increment arbiter and its round-robin picker.
//   - Arbiter FSM state encodings (3-bit, legacy-compatible localparams)
//   - Default settle window between an increment grant and the display refresh
//   - Index-width helper that never returns zero
// -----------------------------------------------------------------------------
package adv_counter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_RWAIT   = 3'd3;
    localparam logic [2:0] ST_REFRESH = 3'd4;

    localparam int HOLDOFF_DEFAULT = 4;

    // Width of an index into n lanes; a single lane still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inc_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: returns the first set pending bit found
// searching ptr, ptr+1, ... wrapping modulo DIGITS.
// Ports:
//   pending [DIGITS-1:0] in  : pending-request bits
//   ptr     [LW-1:0]     in  : lane with highest priority this round
//   valid                out : at least one lane is pending
//   lane    [LW-1:0]     out : index of the selected lane (0 when !valid)
//   onehot  [DIGITS-1:0] out : one-hot of the selected lane (0 when !valid)
// -----------------------------------------------------------------------------
module rr_select
    import adv_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int LW     = idx_width(DIGITS)
) (
    input  logic [DIGITS-1:0] pending,
    input  logic [LW-1:0]     ptr,
    output logic              valid,
    output logic [LW-1:0]     lane,
    output logic [DIGITS-1:0] onehot
);

    // Rotating a doubled copy right by ptr puts lane ptr at bit 0, so the
    // lowest set bit of the low half is the round-robin winner's offset.
    logic [2*DIGITS-1:0] rot_s;
    logic [LW:0]         off_s;
    logic [LW:0]         sum_s;

    assign rot_s = {pending, pending} >> ptr;

    // Find the lowest set offset, then translate it back to an absolute lane.
    always_comb begin
        valid  = 1'b0;
        off_s  = '0;
        sum_s  = '0;
        lane   = '0;
        onehot = '0;
        // Descending scan: the last hit written is the lowest offset.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            valid = valid | rot_s[i];
            off_s = rot_s[i] ? (LW+1)'(i) : off_s;
        end
        sum_s = {1'b0, ptr} + off_s;
        if (sum_s >= (LW+1)'(DIGITS)) begin
            sum_s = sum_s - (LW+1)'(DIGITS);
        end else begin
            sum_s = sum_s;
        end
        if (valid) begin
            lane   = sum_s[LW-1:0];
            onehot = DIGITS'(1'b1) << sum_s[LW-1:0];
        end else begin
            lane   = '0;
            onehot = '0;
        end
    end

endmodule

// File: rtl/inc_arbiter.sv
// -----------------------------------------------------------------------------
// inc_arbiter
// Edge-detects per-digit button lanes, queues one pending request per lane,
// grants lanes round-robin to the digit counters, lets the carry settle for
// HOLDOFF cycles, waits for the serial shifter to go idle and then pulses a
// display refresh.
// Ports:
//   clk                      in  : system clock
//   rst_n                    in  : asynchronous active-low reset
//   ena                      in  : allows a new sequence to start from IDLE
//   req_in     [DIGITS-1:0]  in  : synchronized button levels, one per lane
//   shift_busy               in  : shifter mid-frame, hold refresh off
//   inc_grant  [DIGITS-1:0]  out : one-hot, one-cycle increment strobe
//   refresh                  out : one-cycle display reload strobe
//   busy                     out : FSM is not in IDLE
//   overrun                  out : rise seen on an already-pending lane
//   pending    [DIGITS-1:0]  out : pending-request bits
// -----------------------------------------------------------------------------
module inc_arbiter
    import adv_counter_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DIGITS-1:0] req_in,
    input  logic              shift_busy,
    output logic [DIGITS-1:0] inc_grant,
    output logic              refresh,
    output logic              busy,
    output logic              overrun,
    output logic [DIGITS-1:0] pending
);

    localparam int LW = idx_width(DIGITS);
    localparam int CW = $clog2(HOLDOFF + 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [DIGITS-1:0] req_d_r;
    logic [DIGITS-1:0] pending_r;
    logic [LW-1:0]     lane_r;
    logic [LW-1:0]     ptr_r;
    logic [LW-1:0]     ptr_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic [DIGITS-1:0] inc_grant_r;
    logic              refresh_r;
    logic              busy_r;
    logic              overrun_r;

    logic [DIGITS-1:0] rise_s;
    logic [DIGITS-1:0] clr_s;
    logic              start_s;
    logic              sel_valid_s;
    logic [LW-1:0]     sel_lane_s;
    logic [DIGITS-1:0] sel_onehot_s;

    assign rise_s = req_in & ~req_d_r;
    assign clr_s  = start_s ? sel_onehot_s : '0;

    rr_select #(
        .DIGITS (DIGITS),
        .LW     (LW)
    ) u_rr_select (
        .pending (pending_r),
        .ptr     (ptr_r),
        .valid   (sel_valid_s),
        .lane    (sel_lane_s),
        .onehot  (sel_onehot_s)
    );

    // Next-state and settle-counter logic of the grant/refresh sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ena && sel_valid_s) begin
                    state_nxt_s = ST_GRANT;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_nxt_s = ST_SETTLE;
                cnt_nxt_s   = CW'(HOLDOFF - 1);
            end
            ST_SETTLE: begin
                // Counter is loaded with HOLDOFF-1 so SETTLE spans HOLDOFF cycles.
                if (cnt_r == '0) begin
                    state_nxt_s = ST_RWAIT;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            ST_RWAIT: begin
                if (!shift_busy) begin
                    state_nxt_s = ST_REFRESH;
                end else begin
                    state_nxt_s = ST_RWAIT;
                end
            end
            ST_REFRESH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Pointer advances past the granted lane with an explicit wrap, so
    // non-power-of-two lane counts never land on a nonexistent lane.
    always_comb begin
        if (lane_r == LW'(DIGITS - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = lane_r + LW'(1);
        end
    end

    // Sequencer state, request capture and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            req_d_r     <= '0;
            pending_r   <= '0;
            lane_r      <= '0;
            ptr_r       <= '0;
            inc_grant_r <= '0;
            refresh_r   <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_d_r     <= req_in;
            // A new rise on the lane being cleared keeps it pending.
            pending_r   <= (pending_r & ~clr_s) | rise_s;
            overrun_r   <= |(rise_s & pending_r);
            inc_grant_r <= start_s ? sel_onehot_s : '0;
            refresh_r   <= (state_nxt_s == ST_REFRESH);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (start_s) begin
                lane_r <= sel_lane_s;
            end
            // ptr is only consulted in IDLE, which cannot recur before GRANT
            // ends, so advancing it during GRANT from the stored lane is
            // indistinguishable from advancing it on GRANT entry.
            if (state_r == ST_GRANT) begin
                ptr_r <= ptr_nxt_s;
            end
        end
    end

    assign inc_grant = inc_grant_r;
    assign refresh   = refresh_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign pending   = pending_r;

endmodule
